sample_fifo: RTL

//   Parametrised synchronous FIFO for audio sample streams, e.g. 15-bit song samples

---
 rtl/sample_fifo_pkg.sv | 11 +
 rtl/sample_fifo_if.sv | 35 +++
 rtl/sample_fifo_ram.sv | 45 ++++
 rtl/sample_fifo.sv | 116 +++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared audio-stream constants and elaboration helpers for the sample FIFO.
package sample_fifo_pkg;

  localparam int unsigned SAMPLE_W   = 15;
  localparam int unsigned FIFO_DEPTH = 16;

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Handshake bundle between a sample producer/consumer (master) and the FIFO (slave).
interface sample_fifo_if
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sample_fifo_ram.sv
// Simple dual-port sample store: one write port, one read port whose read is either
// registered (reset to zero, updated only on re) or combinational.
module sample_fifo_ram #(
  parameter int unsigned DATA_W    = 15,
  parameter int unsigned DEPTH     = 16,
  parameter bit          SYNC_READ = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (SYNC_READ) begin : g_sync_read
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb begin
      rdata_d = rdata_q;
      if (re_i) rdata_d = mem_q[raddr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
  end else begin : g_async_read
    logic unused_sync_ports;
    assign unused_sync_ports = ^{re_i, rst_n};
    assign rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/sample_fifo.sv
// Parametrised synchronous sample FIFO with occupancy, threshold flags and sticky
// overflow/underflow; FWFT selects first-word-fall-through or registered reads.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = SAMPLE_W,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AFULL_THR  = DEPTH - 2,
  parameter int unsigned AEMPTY_THR = 1,
  parameter bit          FWFT       = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  sample_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfullCnt  = CNT_W'(AFULL_THR);
  localparam logic [CNT_W-1:0] AemptyCnt = CNT_W'(AEMPTY_THR);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sample_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("sample_fifo: AFULL_THR must lie in 1..DEPTH");
  end
  if (AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("sample_fifo: AEMPTY_THR must lie in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              full_d, full_q, empty_d, empty_q;
  logic              afull_d, afull_q, aempty_d, aempty_q;
  logic              valid_d, valid_q;
  logic              ovf_d, ovf_q, udf_d, udf_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    wr_acc   = bus.wr_en && !full_q;
    rd_acc   = bus.rd_en && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfullCnt);
    aempty_d = (count_d <= AemptyCnt);
    // Registered reads pulse valid per pop; FWFT keeps valid while a head word exists.
    valid_d  = FWFT ? (count_d != '0) : rd_acc;
    // A new error event wins over a simultaneous clear.
    ovf_d    = (bus.wr_en && full_q)  ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    udf_d    = (bus.rd_en && empty_q) ? 1'b1 : (bus.clr_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sample_fifo_ram #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SYNC_READ(!FWFT)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.din),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  // Storage is never reset, so the fall-through view is masked to zero while empty.
  if (FWFT) begin : g_dout_fwft
    assign bus.dout = valid_q ? ram_rdata : '0;
  end else begin : g_dout_std
    assign bus.dout = ram_rdata;
  end

  assign bus.valid        = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
